// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding and default sizes for the sequence detector
package seq_detect_pkg;
  localparam int MAX_LEN_D = 8;
  localparam int CNT_W_D = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial history, fill counter and masked pattern compare
module seq_match_core #(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         len,
  input  logic               overlap,
  output logic               hit
);
  localparam int FW = $clog2(MAX_LEN + 1);
  logic [MAX_LEN-1:0] hist, nh, mask;
  logic [FW-1:0] fill, nf;
  always_comb begin
    nh = {hist[MAX_LEN-2:0], x};
    mask = ~({MAX_LEN{1'b1}} << len);
    nf = (fill == FW'(MAX_LEN)) ? fill : fill + 1'b1;
    hit = en && (((nh ^ pattern) & mask) == '0) && (32'(nf) >= 32'(len));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= nh;
      fill <= (hit && !overlap) ? '0 : nf;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-control FSM, latched configuration and match counting
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x_valid,
  input  logic               x,
  output logic               z,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  state_t state, nxt;
  logic [MAX_LEN-1:0] pat;
  logic [3:0] len;
  logic ovl, legal, go, hit, take;
  logic [CNT_W-1:0] tgt, nc;
  seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk(clk), .rst(rst), .clr(go), .en(state == RUN && x_valid), .x(x),
    .pattern(pat), .len(len), .overlap(ovl), .hit(hit)
  );
  always_comb begin
    legal = (len >= 4'd2) && (32'(len) <= 32'(MAX_LEN));
    go = (state == IDLE) && start && legal;
    take = (state == RUN) && hit && !abort;
    nc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
    nxt = state;
    case (state)
      IDLE: nxt = go ? RUN : IDLE;
      RUN:  nxt = abort ? IDLE : (take && tgt != '0 && nc == tgt) ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      z <= 1'b0;
      cfg_err <= 1'b0;
      match_cnt <= '0;
      pat <= '0;
      len <= 4'd4;
      ovl <= 1'b0;
      tgt <= CNT_W'(1);
    end else begin
      state <= nxt;
      z <= take;
      cfg_err <= (state == IDLE) && start && !legal;
      match_cnt <= go ? '0 : take ? nc : match_cnt;
      if (state == IDLE && cfg_we) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        tgt <= cfg_target;
      end
    end
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed requirement scenarios plus randomized runs against a queue-based model
module tb_seq_detect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0, cfg_overlap = 1'b0, start = 1'b0, abort = 1'b0, x_valid = 1'b0, x = 1'b0;
  logic [7:0] cfg_pattern = '0, cfg_target = '0;
  logic [3:0] cfg_len = '0;
  logic z, busy, done, cfg_err;
  logic [7:0] match_cnt;
  int n_tests = 0, n_fail = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .x_valid(x_valid), .x(x), .z(z), .busy(busy), .done(done), .match_cnt(match_cnt),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic st, input logic ab, input logic v, input logic b);
    start = st; abort = ab; x_valid = v; x = b;
    tick();
    start = 0; abort = 0; x_valid = 0; x = 0;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic [7:0] t);
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    #3;
    n_tests++;
    if ({z, busy, done, cfg_err, match_cnt} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got z=%b busy=%b done=%b err=%b cnt=%0d, want all 0", z, busy, done, cfg_err, match_cnt);
    end
    rst = 1;
    tick();
    cyc(1, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL default_start: busy=%b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (z !== (i == 3) || done !== (i == 3)) begin
        n_fail++; $display("FAIL default_cfg bit%0d: z=%b done=%b want %b", i, z, done, i == 3);
      end
    end
    n_tests++;
    if (match_cnt !== 8'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL default_target: cnt=%0d busy=%b want 1/0", match_cnt, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL done_width: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s = 7'b1011011;
    cfg(8'b1011, 4, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, s[6-i]);
      n_tests++;
      if (z !== (i == 3)) begin n_fail++; $display("FAIL nonoverlap_z bit%0d: z=%b want %b", i + 1, z, i == 3); end
    end
    n_tests++;
    if (match_cnt !== 8'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL nonoverlap_cnt: cnt=%0d busy=%b want 1/1", match_cnt, busy);
    end
    cyc(0, 1, 0, 0);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL abort_hold: busy=%b done=%b cnt=%0d want 0/0/1", busy, done, match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s = 7'b1011011;
    cfg(8'b1011, 4, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, s[6-i]);
      n_tests++;
      if (z !== (i == 3 || i == 6)) begin n_fail++; $display("FAIL overlap_z bit%0d: z=%b want %b", i + 1, z, i == 3 || i == 6); end
    end
    n_tests++;
    if (match_cnt !== 8'd2) begin n_fail++; $display("FAIL overlap_cnt: cnt=%0d want 2", match_cnt); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_target_done();
    logic [6:0] s = 7'b1011011;
    cfg(8'b1011, 4, 1, 2);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, s[6-i]);
      n_tests++;
      if (done !== (i == 6) || busy !== (i != 6)) begin
        n_fail++; $display("FAIL target_done bit%0d: done=%b busy=%b want %b/%b", i + 1, done, busy, i == 6, i != 6);
      end
    end
    n_tests++;
    if (z !== 1'b1 || match_cnt !== 8'd2) begin n_fail++; $display("FAIL target_z: z=%b cnt=%0d want 1/2", z, match_cnt); end
    tick();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL target_after: done=%b busy=%b cnt=%0d want 0/0/2", done, busy, match_cnt);
    end
    cyc(1, 0, 0, 0);
    n_tests++;
    if (busy !== 1'b1 || match_cnt !== 8'd0) begin n_fail++; $display("FAIL restart: busy=%b cnt=%0d want 1/0", busy, match_cnt); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_gaps_abort();
    logic [7:0] v = 8'b10011011;
    logic [7:0] b = 8'b10001011;
    cfg(8'b1011, 4, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, v[7-i], b[7-i]);
      n_tests++;
      if (z !== (i == 6)) begin n_fail++; $display("FAIL gaps_z cyc%0d: z=%b want %b", i, z, i == 6); end
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    n_tests++;
    if (z !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL abort_discard: z=%b busy=%b done=%b cnt=%0d want 0/0/0/0", z, busy, done, match_cnt);
    end
  endtask

  task automatic test_cfg_err();
    cfg(8'b1011, 1, 0, 0);
    cyc(1, 0, 0, 0);
    n_tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_len1: err=%b busy=%b want 1/0", cfg_err, busy); end
    tick();
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: err=%b busy=%b want 0/0", cfg_err, busy); end
    cfg(8'b1011, 9, 0, 0);
    cyc(1, 0, 0, 0);
    n_tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_len9: err=%b busy=%b want 1/0", cfg_err, busy); end
    cfg(8'b1011, 4, 0, 0);
    cyc(1, 0, 0, 0);
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cfg_legal: err=%b busy=%b want 0/1", cfg_err, busy); end
    cfg(8'b0000, 2, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    n_tests++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL cfg_we_run_early: z=%b want 0", z); end
    cyc(0, 0, 1, 1);
    n_tests++;
    if (z !== 1'b1 || busy !== 1'b1 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL cfg_we_run: z=%b busy=%b cnt=%0d want 1/1/1", z, busy, match_cnt);
    end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_reset_midrun();
    cfg(8'b11, 2, 1, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
    n_tests++;
    if (match_cnt !== 8'd3 || z !== 1'b1) begin n_fail++; $display("FAIL midrun_cnt: cnt=%0d z=%b want 3/1", match_cnt, z); end
    x_valid = 1; x = 1;
    #2 rst = 0;
    #1;
    n_tests++;
    if ({z, busy, done, cfg_err, match_cnt} !== 12'h0) begin
      n_fail++; $display("FAIL async_reset: z=%b busy=%b done=%b err=%b cnt=%0d want all 0", z, busy, done, cfg_err, match_cnt);
    end
    tick();
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0);
      n_tests++;
      if (z !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL no_restart cyc%0d: z=%b busy=%b want 0/0", i, z, busy); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      logic [7:0] p = 8'($urandom);
      logic [3:0] l = 4'($urandom_range(2, 8));
      logic o = 1'($urandom);
      logic [7:0] t = 8'($urandom_range(0, 4));
      bit q[$];
      logic [7:0] cnt = 0;
      bit live = 1;
      cfg(p, l, o, t);
      cyc(1, 0, 0, 0);
      for (int c = 0; c < 80 && live; c++) begin
        logic v = ($urandom_range(0, 3) != 0);
        logic b = 1'($urandom);
        logic ab = ($urandom_range(0, 59) == 0);
        logic ez = 0, ed = 0, m = 0;
        if (v) begin
          q.push_back(b);
          if (q.size() > 8) void'(q.pop_front());
          if (q.size() >= int'(l)) begin
            m = 1;
            for (int i = 0; i < int'(l); i++) if (q[q.size() - 1 - i] != p[i]) m = 0;
          end
          if (m && !ab) begin
            ez = 1;
            if (cnt != 8'hff) cnt++;
            ed = (t != 0 && cnt == t);
          end
          if (m && !o) q.delete();
        end
        cyc(0, ab, v, b);
        n_tests++;
        if (z !== ez || done !== ed || busy !== (!ab && !ed) || match_cnt !== cnt) begin
          n_fail++;
          $display("FAIL random run%0d cyc%0d: z=%b done=%b busy=%b cnt=%0d want %b/%b/%b/%0d",
                   r, c, z, done, busy, match_cnt, ez, ed, !ab && !ed, cnt);
        end
        live = !ab && !ed;
      end
      if (live) cyc(0, 1, 0, 0);
      cyc(0, 0, 1'($urandom), 1'($urandom));
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== cnt) begin
        n_fail++; $display("FAIL random_end run%0d: busy=%b done=%b cnt=%0d want 0/0/%0d", r, busy, done, match_cnt, cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_target_done();
    test_gaps_abort();
    test_cfg_err();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
